uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-level frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle `rx_vld` byte strobes and assembles framed commands (start-of-frame, opcode, length, payload, XOR checksum). It presents each validated command on a valid/ready interface to the register/control logic. Malformed frames, inter-byte timeouts and overruns are reported as one-cycle error pulses with a code.

## Interface
- `FREQ`, 50_000_000: clock frequency in Hz; documentation only.
- `TIMEOUT_CYC`, 50_000: maximum idle cycles between bytes inside a frame.
- `MAX_LEN`, 4: maximum payload bytes; range 1..4.
- `SOF`, 8'hA5: start-of-frame byte.
- `clk`  in  1: clock.
- `nrst`  in  1: reset, asynchronous, active-low.
- `rx_data`  in  8: received byte; valid only while `rx_vld` is high.
- `rx_vld`  in  1: one-cycle strobe per received byte.
- `cmd_valid`  out  1: command available.
- `cmd_ready`  in  1: consumer accepts the command.
- `cmd_op`  out  8: opcode.
- `cmd_len`  out  3: payload byte count, 0..MAX_LEN.
- `cmd_payload`  out  32: payload; byte i is in bits [8i+7:8i]; unused bytes are 0.
- `err_pulse`  out  1: one-cycle error strobe.
- `err_code`  out  2: error code. 0 = checksum, 1 = length, 2 = timeout, 3 = overrun. Held until the next error.

## Operation
- Frame format: SOF, OP, LEN, LEN payload bytes, CHK.
  - CHK = OP ^ LEN ^ each payload byte.
- States: IDLE, OP, LEN, DATA, CHK, HOLD.
- IDLE:
  - A byte equal to SOF moves to OP.
  - Any other byte is dropped silently, with no error.
- OP: latch the opcode, initialise the checksum accumulator to OP, go to LEN.
- LEN:
  - LEN > MAX_LEN: error 1, go to IDLE.
  - LEN = 0: go to CHK.
  - Otherwise: clear the payload register, clear the byte index, go to DATA.
- DATA:
  - Store the byte at the current index and XOR it into the accumulator.
  - After the LEN-th byte, go to CHK.
- CHK:
  - Byte equals the accumulator: go to HOLD and assert `cmd_valid`.
  - Mismatch: error 0, go to IDLE.
- HOLD:
  - `cmd_*` outputs are stable while `cmd_valid` is high.
  - `cmd_valid && cmd_ready`: go to IDLE.
  - A byte arriving in HOLD is dropped and raises error 3. The state stays HOLD and the command is preserved.
  - If `cmd_ready` is high in the same cycle as a byte arrives, the handshake completes, that byte is dropped, and error 3 is raised.
- Timeout:
  - The counter runs in OP, LEN, DATA and CHK, and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYC-1: error 2, go to IDLE.
  - If a byte and the timeout occur in the same cycle, the byte wins and there is no error.
  - The counter is not active in IDLE or HOLD.
- A SOF byte received mid-frame is treated as ordinary data; there is no resynchronisation.
- Reset, including assertion mid-frame:
  - State returns to IDLE; all counters, the accumulator and the payload are cleared.
  - `cmd_valid`, `err_pulse`, `err_code`, `cmd_op`, `cmd_len` and `cmd_payload` are all 0.

## Timing
- All outputs are registered.
- `cmd_valid` rises on the clk edge after the cycle in which the CHK byte's `rx_vld` is sampled.
- `cmd_valid` falls on the edge after the handshake cycle.
- `err_pulse` is high for exactly the one cycle following the offending event (byte or timeout).
- Back-to-back `rx_vld` in consecutive cycles must be accepted. The design has no internal bubble; throughput is 1 byte/cycle.
- The timeout counter width is clog2(TIMEOUT_CYC) bits; wrap-around cannot occur because the counter is cleared at terminal count.

## Structure
- Package `uart_cmd_pkg` holds:
  - the SOF default;
  - the state encoding;
  - the error code constants `ERR_CHK`, `ERR_LEN`, `ERR_TMO`, `ERR_OVR`.
- One natural sub-module: `uart_timeout_timer`.
  - Inputs: `clk`, `nrst`, `en`, `clr`. Output: one-cycle `expire` at TIMEOUT_CYC-1.
- The FSM, payload shift/index logic and checksum accumulator stay in the top module.

## Test plan
- Good frame:
  - Stimulus: bytes A5 12 02 34 56 72, then `cmd_ready` = 1.
  - Response: `cmd_valid`, `cmd_op` = 12, `cmd_len` = 2, `cmd_payload` = 0000_5634, no error.
- Zero-length frame:
  - Stimulus: A5 07 00 07.
  - Response: `cmd_op` = 07, `cmd_len` = 0, `cmd_payload` = 0.
- Bad checksum and bad length:
  - Stimulus: A5 12 02 34 56 73.
  - Response: `err_pulse` with code 0, no `cmd_valid`.
  - Stimulus: A5 12 05.
  - Response: code 1 one cycle after the LEN byte; the next good frame decodes correctly.
- Timeout:
  - Stimulus: A5 12, then silence for TIMEOUT_CYC cycles.
  - Response: code 2, return to IDLE. A byte landing exactly on the expiry cycle produces no error.
- Overrun and backpressure:
  - Stimulus: good frame, `cmd_ready` held 0 for 100 cycles, byte 55 sent.
  - Response: code 3; `cmd_*` unchanged until `cmd_ready` = 1.
- Reset and noise:
  - Stimulus: `nrst` pulsed low after A5 12 02 34.
  - Response: all outputs 0; a subsequent good frame decodes.
  - Stimulus: leading bytes 00 FF.
  - Response: ignored, with no error.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame decoder: frame marker,
// FSM state encoding and error codes reported on err_code.
package uart_cmd_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD
  } state_t;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expire for the single cycle the count sits at TIMEOUT_CYC-1.
module uart_timeout_timer #(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;
  logic         at_term;

  assign at_term = (cnt == TERM);
  // A clear in the terminal cycle suppresses expire: the byte wins.
  assign expire  = en && !clr && at_term;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                      cnt <= '0;
    else if (clr || !en || at_term) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles SOF/OP/LEN/payload/CHK frames from UART byte strobes into
// commands on a valid/ready port; framing faults pulse err_pulse/err_code.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         FREQ        = 50_000_000,
  parameter int         TIMEOUT_CYC = 50_000,
  parameter int         MAX_LEN     = 4,
  parameter logic [7:0] SOF         = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  if (MAX_LEN < 1 || MAX_LEN > 4 || FREQ <= 0) begin : g_param_chk
    $error("uart_cmd_decoder: MAX_LEN must be 1..4 and FREQ positive");
  end

  state_t      state;
  logic [7:0]  op_r;
  logic [7:0]  acc;
  logic [2:0]  len_r;
  logic [1:0]  idx;
  logic [31:0] pay_r;
  logic        tmo_en;
  logic        expire;

  assign tmo_en = (state == S_OP) || (state == S_LEN) ||
                  (state == S_DATA) || (state == S_CHK);

  uart_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .nrst   (nrst),
    .en     (tmo_en),
    .clr    (rx_vld),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      op_r        <= '0;
      acc         <= '0;
      len_r       <= '0;
      idx         <= '0;
      pay_r       <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_CHK;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: if (rx_vld && rx_data == SOF) state <= S_OP;
        // Command held stable; stray bytes are overruns, handshake still completes.
        S_HOLD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (rx_vld) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_OVR;
          end
        end
        default: begin
          if (rx_vld) begin
            case (state)
              S_OP: begin
                op_r  <= rx_data;
                acc   <= rx_data;
                state <= S_LEN;
              end
              S_LEN: begin
                if (rx_data > 8'(MAX_LEN)) begin
                  err_pulse <= 1'b1;
                  err_code  <= ERR_LEN;
                  state     <= S_IDLE;
                end else begin
                  len_r <= rx_data[2:0];
                  acc   <= acc ^ rx_data;
                  pay_r <= '0;
                  idx   <= '0;
                  state <= (rx_data == 8'd0) ? S_CHK : S_DATA;
                end
              end
              S_DATA: begin
                pay_r[{idx, 3'b000} +: 8] <= rx_data;
                acc <= acc ^ rx_data;
                idx <= idx + 2'd1;
                if ({1'b0, idx} == len_r - 3'd1) state <= S_CHK;
              end
              S_CHK: begin
                if (rx_data == acc) begin
                  cmd_valid   <= 1'b1;
                  cmd_op      <= op_r;
                  cmd_len     <= len_r;
                  cmd_payload <= pay_r;
                  state       <= S_HOLD;
                end else begin
                  err_pulse <= 1'b1;
                  err_code  <= ERR_CHK;
                  state     <= S_IDLE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end else if (expire) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Frame-table and corner-sequence bench for uart_cmd_decoder; expected
// commands and error codes are queued at stimulus time and popped by a monitor.
module tb_uart_cmd_decoder;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        err_pulse;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  len;
    logic [31:0] pay;
  } cmd_t;

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              kind;   // 0 none, 1 command, 2 error
    logic [7:0]      op;
    logic [2:0]      len;
    logic [31:0]     pay;
    logic [1:0]      code;
  } vec_t;

  cmd_t       cmd_q[$];
  logic [1:0] err_q[$];
  vec_t       vecs[8];

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  // Scoreboard monitor: consumes one expectation per handshake / error pulse.
  always @(negedge clk) begin
    if (nrst) begin
      if (cmd_valid && cmd_ready) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got op=%h len=%0d pay=%h want none", cmd_op, cmd_len, cmd_payload);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          if (cmd_op !== e.op || cmd_len !== e.len || cmd_payload !== e.pay) begin
            errors++;
            $display("FAIL cmd got op=%h len=%0d pay=%h want op=%h len=%0d pay=%h",
                     cmd_op, cmd_len, cmd_payload, e.op, e.len, e.pay);
          end
        end
      end
      if (err_pulse) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err got code=%0d want none", err_code);
        end else begin
          logic [1:0] ec;
          ec = err_q.pop_front();
          if (err_code !== ec) begin
            errors++;
            $display("FAIL err_code got=%0d want=%0d", err_code, ec);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Caller is always at posedge+1; consecutive calls give back-to-back strobes.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [2:0] len, input logic [31:0] pay);
    cmd_t c;
    c.op = op; c.len = len; c.pay = pay;
    cmd_q.push_back(c);
  endtask

  task automatic good_frame();
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h56);
    push_cmd(8'h12, 3'd2, 32'h0000_5634);
    send_byte(8'h72);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, cmd_valid}, 32'd0);
    chk({tag, "_op"},    {24'b0, cmd_op},    32'd0);
    chk({tag, "_len"},   {29'b0, cmd_len},   32'd0);
    chk({tag, "_pay"},   cmd_payload,        32'd0);
    chk({tag, "_errp"},  {31'b0, err_pulse}, 32'd0);
    chk({tag, "_errc"},  {30'b0, err_code},  32'd0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{b: {8'hA5,8'h12,8'h02,8'h34,8'h56,8'h72,8'h00,8'h00}, n: 6, kind: 1, op: 8'h12, len: 3'd2, pay: 32'h0000_5634, code: 2'd0};
    vecs[1] = '{b: {8'hA5,8'h07,8'h00,8'h07,8'h00,8'h00,8'h00,8'h00}, n: 4, kind: 1, op: 8'h07, len: 3'd0, pay: 32'h0,         code: 2'd0};
    vecs[2] = '{b: {8'hA5,8'h12,8'h02,8'h34,8'h56,8'h73,8'h00,8'h00}, n: 6, kind: 2, op: 8'h00, len: 3'd0, pay: 32'h0,         code: 2'd0};
    vecs[3] = '{b: {8'hA5,8'h12,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 3, kind: 2, op: 8'h00, len: 3'd0, pay: 32'h0,         code: 2'd1};
    vecs[4] = '{b: {8'h00,8'hFF,8'hA5,8'h12,8'h02,8'h34,8'h56,8'h72}, n: 8, kind: 1, op: 8'h12, len: 3'd2, pay: 32'h0000_5634, code: 2'd0};
    vecs[5] = '{b: {8'hA5,8'h3C,8'h04,8'h11,8'h22,8'h33,8'h44,8'h7C}, n: 8, kind: 1, op: 8'h3C, len: 3'd4, pay: 32'h4433_2211, code: 2'd0};
    vecs[6] = '{b: {8'hA5,8'h20,8'h01,8'h99,8'hB8,8'h00,8'h00,8'h00}, n: 5, kind: 1, op: 8'h20, len: 3'd1, pay: 32'h0000_0099, code: 2'd0};
    vecs[7] = '{b: {8'hA5,8'h01,8'h01,8'hA5,8'hA5,8'h00,8'h00,8'h00}, n: 5, kind: 1, op: 8'h01, len: 3'd1, pay: 32'h0000_00A5, code: 2'd0};

    nrst = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    nrst = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        if (j == vecs[i].n - 1) begin
          if (vecs[i].kind == 1) push_cmd(vecs[i].op, vecs[i].len, vecs[i].pay);
          if (vecs[i].kind == 2) err_q.push_back(vecs[i].code);
        end
        send_byte(vecs[i].b[j]);
      end
      idle(3);
    end

    // Length error is a single-cycle pulse right after the LEN byte.
    send_byte(8'hA5); send_byte(8'h12);
    err_q.push_back(2'd1);
    send_byte(8'h06);
    chk("len_err_pulse", {31'b0, err_pulse}, 32'd1);
    chk("len_err_code",  {30'b0, err_code},  32'd1);
    idle(1);
    chk("len_err_one_cycle", {31'b0, err_pulse}, 32'd0);
    good_frame();
    idle(3);

    // Silence for TMO cycles inside a frame times out; err_code then holds.
    send_byte(8'hA5); send_byte(8'h12);
    err_q.push_back(2'd2);
    idle(TMO + 2);
    idle(10);
    chk("tmo_code_held", {30'b0, err_code}, 32'd2);

    // Byte arriving exactly on the expiry cycle wins.
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h02);
    idle(TMO - 1);
    send_byte(8'h34); send_byte(8'h56);
    push_cmd(8'h12, 3'd2, 32'h0000_5634);
    send_byte(8'h72);
    idle(3);

    // Backpressure then overrun: command must stay intact.
    cmd_ready = 1'b0;
    good_frame();
    chk("valid_latency", {31'b0, cmd_valid}, 32'd1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_valid !== 1'b1 || cmd_op !== 8'h12 || cmd_len !== 3'd2 || cmd_payload !== 32'h5634) bad++;
      idle(1);
    end
    chk("hold_stable_cycles_bad", bad, 32'd0);
    err_q.push_back(2'd3);
    send_byte(8'h55);
    chk("ovr_pulse", {31'b0, err_pulse}, 32'd1);
    chk("ovr_code",  {30'b0, err_code},  32'd3);
    idle(5);
    chk("ovr_keeps_valid", {31'b0, cmd_valid}, 32'd1);
    chk("ovr_keeps_pay",   cmd_payload,        32'h0000_5634);
    cmd_ready = 1'b1;
    idle(1);
    chk("valid_falls", {31'b0, cmd_valid}, 32'd0);
    idle(2);

    // Byte and handshake in the same cycle: both happen, byte is an overrun.
    cmd_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00);
    push_cmd(8'h07, 3'd0, 32'h0);
    send_byte(8'h07);
    idle(2);
    err_q.push_back(2'd3);
    cmd_ready = 1'b1;
    send_byte(8'h55);
    chk("sim_ovr_code", {30'b0, err_code}, 32'd3);
    chk("sim_valid_low", {31'b0, cmd_valid}, 32'd0);
    idle(2);
    good_frame();
    idle(3);

    // Reset mid-frame clears everything; a fresh frame must decode cleanly.
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h02); send_byte(8'h34);
    nrst = 1'b0;
    #2;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(1);
    good_frame();
    idle(5);

    chk("cmd_q_drained", cmd_q.size(), 32'd0);
    chk("err_q_drained", err_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
